// File: rtl/adxl362_spi_responder.sv
// ADXL362 SPI responder: emulates the sensor's register file on a mode-0 SPI bus, all logic on clk.
// Optional soft reset (write 0x52 to 0x1F) is built when ADXL_SOFT_RESET_EN is defined.
module adxl362_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID_AD    = 8'hAD,
    parameter logic [7:0] PARTID      = 8'hF2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS,
    output logic        MISO,
    input  logic [11:0] accel_x_in,
    input  logic [11:0] accel_y_in,
    input  logic [11:0] accel_z_in,
    input  logic [11:0] temp_in,
    output logic [7:0]  power_ctl,
    output logic        xfer_done,
    output logic        cmd_err
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WRITE, READ, IGNORE} state_t;

    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic        sclk_prev_q, ss_prev_q;
    logic        sclk_s, mosi_s, ss_s;
    logic        sclk_rise, sclk_fall, ss_rise, ss_fall, byte_done;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  rx_q, tx_q, addr_q, rx_shift, rdata;
    logic        wr_mode_q, wr_mode_d;
    logic        miso_q, byte_seen_q, xfer_done_q, cmd_err_q, cmd_err_d;
    logic [11:0] snap_x_q, snap_y_q, snap_z_q, snap_t_q;
    logic [7:0]  regs_q [15];
    logic        wr_en, soft_rst, in_regs;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;
    assign rx_shift  = {rx_q[6:0], mosi_s};
    // ss_s low already excludes a simultaneous SS rise; a select edge wins over SCLK
    assign byte_done = sclk_rise & ~ss_s & ~ss_fall & (bit_cnt_q == 3'd7);
    assign in_regs   = (addr_q[7:4] == 4'h2) && (addr_q[3:0] != 4'hF);
    assign wr_en     = byte_done && (state_q == WRITE) && in_regs;

`ifdef ADXL_SOFT_RESET_EN
    assign soft_rst  = byte_done && (state_q == WRITE) && (addr_q == 8'h1F) && (rx_shift == 8'h52);
`else
    assign soft_rst  = 1'b0;
`endif

    assign power_ctl = regs_q[13];
    assign MISO      = miso_q;
    assign xfer_done = xfer_done_q;
    assign cmd_err   = cmd_err_q;

    always_comb begin
        state_d   = state_q;
        wr_mode_d = wr_mode_q;
        cmd_err_d = 1'b0;
        if (ss_rise) begin
            state_d = IDLE;
        end else if (ss_fall) begin
            state_d = CMD;
        end else if (byte_done) begin
            case (state_q)
                CMD: begin
                    if (rx_shift == 8'h0A) begin
                        state_d   = ADDR;
                        wr_mode_d = 1'b1;
                    end else if (rx_shift == 8'h0B) begin
                        state_d   = ADDR;
                        wr_mode_d = 1'b0;
                    end else begin
                        state_d   = IGNORE;
                        cmd_err_d = 1'b1;
                    end
                end
                ADDR:    state_d = wr_mode_q ? WRITE : READ;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (addr_q)
            8'h00: rdata = DEVID_AD;
            8'h01: rdata = 8'h1D;
            8'h02: rdata = PARTID;
            8'h03: rdata = 8'h01;
            8'h08: rdata = snap_x_q[11:4];
            8'h09: rdata = snap_y_q[11:4];
            8'h0A: rdata = snap_z_q[11:4];
            8'h0B: rdata = {7'd0, regs_q[13][1:0] == 2'b10};
            8'h0E: rdata = snap_x_q[7:0];
            8'h0F: rdata = {{4{snap_x_q[11]}}, snap_x_q[11:8]};
            8'h10: rdata = snap_y_q[7:0];
            8'h11: rdata = {{4{snap_y_q[11]}}, snap_y_q[11:8]};
            8'h12: rdata = snap_z_q[7:0];
            8'h13: rdata = {{4{snap_z_q[11]}}, snap_z_q[11:8]};
            8'h14: rdata = snap_t_q[7:0];
            8'h15: rdata = {{4{snap_t_q[11]}}, snap_t_q[11:8]};
            default: if (in_regs) rdata = regs_q[addr_q[3:0]];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            state_q     <= IDLE;
            wr_mode_q   <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            addr_q      <= 8'h00;
            miso_q      <= 1'b0;
            byte_seen_q <= 1'b0;
            xfer_done_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            snap_x_q    <= 12'd0;
            snap_y_q    <= 12'd0;
            snap_z_q    <= 12'd0;
            snap_t_q    <= 12'd0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
            state_q     <= state_d;
            wr_mode_q   <= wr_mode_d;
            xfer_done_q <= 1'b0;
            cmd_err_q   <= cmd_err_d;
            if (ss_rise) begin
                miso_q      <= 1'b0;
                bit_cnt_q   <= 3'd0;
                xfer_done_q <= byte_seen_q;
                byte_seen_q <= 1'b0;
            end else if (ss_fall) begin
                bit_cnt_q   <= 3'd0;
                rx_q        <= 8'h00;
                tx_q        <= 8'h00;
                miso_q      <= 1'b0;
                byte_seen_q <= 1'b0;
                snap_x_q    <= accel_x_in;
                snap_y_q    <= accel_y_in;
                snap_z_q    <= accel_z_in;
                snap_t_q    <= temp_in;
            end else if (!ss_s) begin
                if (sclk_rise) begin
                    rx_q      <= rx_shift;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        byte_seen_q <= 1'b1;
                        if (state_q == ADDR)
                            addr_q <= rx_shift;
                        else if (state_q == WRITE || state_q == READ)
                            addr_q <= addr_q + 8'd1;
                    end
                end else if (sclk_fall && state_q == READ) begin
                    // load on the fall ahead of a byte so bit 7 is valid before its first rise
                    if (bit_cnt_q == 3'd0) begin
                        tx_q   <= rdata;
                        miso_q <= rdata[7];
                    end else begin
                        tx_q   <= {tx_q[6:0], 1'b0};
                        miso_q <= tx_q[6];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= (i == 12) ? 8'h13 : 8'h00;
        end else if (soft_rst) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= (i == 12) ? 8'h13 : 8'h00;
        end else if (wr_en) begin
            regs_q[addr_q[3:0]] <= rx_shift;
        end
    end

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Directed bench for adxl362_spi_responder: SPI master tasks, read-data scoreboard queue.
module tb_adxl362_spi_responder;

    logic        clk = 1'b0, reset = 1'b0, SCLK = 1'b0, MOSI = 1'b0, SS = 1'b1;
    logic        MISO, xfer_done, cmd_err;
    logic [11:0] ax = 12'd0, ay = 12'd0, az = 12'd0, at = 12'd0;
    logic [7:0]  power_ctl;
    logic [7:0]  exp_q [$];
    logic [7:0]  r, e;
    int          errors = 0, checks = 0, xfer_cnt = 0, cerr_cnt = 0, base;

    adxl362_spi_responder dut (
        .clk(clk), .reset(reset), .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO),
        .accel_x_in(ax), .accel_y_in(ay), .accel_z_in(az), .temp_in(at),
        .power_ctl(power_ctl), .xfer_done(xfer_done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (xfer_done) xfer_cnt++;
        if (cmd_err) cerr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            MOSI = tx[i];
            #80 SCLK = 1'b1;
            rx[i] = MISO;
            #80 SCLK = 1'b0;
        end
    endtask

    task automatic sel();
        SS = 1'b0;
        #160;
    endtask

    task automatic desel();
        #160 SS = 1'b1;
        #160;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] obs);
        logic [7:0] ev;
        if (exp_q.size() == 0) begin
            check({tag, "_empty"}, 32'd1, 32'd0);
        end else begin
            ev = exp_q.pop_front();
            check(tag, {24'd0, obs}, {24'd0, ev});
        end
    endtask

    task automatic spi_write(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] rr;
        sel();
        spi_byte(8'h0A, rr);
        spi_byte(a, rr);
        spi_byte(d, rr);
        desel();
    endtask

    task automatic spi_read(input string tag, input logic [7:0] a, input int n);
        logic [7:0] rr;
        sel();
        spi_byte(8'h0B, rr);
        spi_byte(a, rr);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, rr);
            pop_check(tag, rr);
        end
        desel();
    endtask

    initial begin
        #50;
        check("rst_miso", {31'd0, MISO}, 32'd0);
        check("rst_power_ctl", {24'd0, power_ctl}, 32'h00);
        check("rst_xfer_done", {31'd0, xfer_done}, 32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        #50 reset = 1'b1;
        #100;

        base = xfer_cnt;
        exp_q.push_back(8'hAD); exp_q.push_back(8'h1D);
        exp_q.push_back(8'hF2); exp_q.push_back(8'h01);
        spi_read("devid", 8'h00, 4);
        check("devid_xfer_done", xfer_cnt - base, 32'd1);
        check("idle_miso", {31'd0, MISO}, 32'd0);

        ax = 12'hF35; ay = 12'h07C; az = 12'h9C4; at = 12'h8E1;
        exp_q.push_back(8'hF3); exp_q.push_back(8'h07); exp_q.push_back(8'h9C);
        spi_read("axis_hi", 8'h08, 3);

        // inputs change after the first data byte; the snapshot must hold
        sel();
        spi_byte(8'h0B, r);
        spi_byte(8'h0E, r);
        exp_q.push_back(8'h35); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h7C); exp_q.push_back(8'h00);
        spi_byte(8'h00, r); pop_check("burst", r);
        ax = 12'h0AB; ay = 12'h801;
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'h00, r); pop_check("burst", r);
        end
        desel();

        exp_q.push_back(8'hE1); exp_q.push_back(8'hF8);
        spi_read("temp", 8'h14, 2);

        check("no_cmd_err_yet", cerr_cnt, 32'd0);

        sel();
        spi_byte(8'h0A, r);
        spi_byte(8'h2D, r);
        spi_byte(8'h02, r);
        check("wr_power_ctl", {24'd0, power_ctl}, 32'h02);
        desel();
        exp_q.push_back(8'h01);
        spi_read("status", 8'h0B, 1);
        exp_q.push_back(8'h13); exp_q.push_back(8'h02);
        spi_read("filter_pwr", 8'h2C, 2);

        // abort after 5 data bits of a write
        sel();
        spi_byte(8'h0A, r);
        spi_byte(8'h2D, r);
        for (int i = 0; i < 5; i++) begin
            MOSI = 1'b0;
            #80 SCLK = 1'b1;
            #80 SCLK = 1'b0;
        end
        desel();
        check("abort_power_ctl", {24'd0, power_ctl}, 32'h02);

        base = cerr_cnt;
        sel();
        spi_byte(8'h0D, r);
        spi_byte(8'h2D, r);
        check("badcmd_miso0", {24'd0, r}, 32'h00);
        spi_byte(8'h00, r);
        check("badcmd_miso1", {24'd0, r}, 32'h00);
        desel();
        check("badcmd_cmd_err", cerr_cnt - base, 32'd1);
        check("badcmd_power_ctl", {24'd0, power_ctl}, 32'h02);

        // reset during data phase: 0xAD bit 5 is on MISO after two data bits
        sel();
        spi_byte(8'h0B, r);
        spi_byte(8'h00, r);
        for (int i = 0; i < 2; i++) begin
            #80 SCLK = 1'b1;
            #80 SCLK = 1'b0;
        end
        #40;
        check("pre_rst_miso", {31'd0, MISO}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_miso", {31'd0, MISO}, 32'd0);
        check("midrst_power_ctl", {24'd0, power_ctl}, 32'h00);
        #19 reset = 1'b1;
        #40 SS = 1'b1;
        #160;
        exp_q.push_back(8'hAD);
        spi_read("post_rst_devid", 8'h00, 1);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h13);
        spi_read("post_rst_regs", 8'h2A, 3);

        spi_write(8'h2D, 8'h02);
        check("sr_setup", {24'd0, power_ctl}, 32'h02);
        spi_write(8'h2C, 8'h44);
        spi_write(8'h1F, 8'h51);
        check("sr_0x51", {24'd0, power_ctl}, 32'h02);
        spi_write(8'h1F, 8'h52);
`ifdef ADXL_SOFT_RESET_EN
        check("sr_0x52", {24'd0, power_ctl}, 32'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h13);
`else
        check("sr_0x52", {24'd0, power_ctl}, 32'h02);
        exp_q.push_back(8'h00); exp_q.push_back(8'h44);
`endif
        spi_read("sr_1f_2c", 8'h1F, 1);
        e = 8'h00;
        sel();
        spi_byte(8'h0B, r);
        spi_byte(8'h2C, r);
        spi_byte(8'h00, r);
        pop_check("sr_filter", r);
        desel();
        check("queue_drained", exp_q.size(), 32'd0);
        check("final_miso", {24'd0, e} | {31'd0, MISO}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adxl362_spi_responder.md
Name: adxl362_spi_responder

Overview:
- SPI slave model of the ADXL362 accelerometer, the responder side of the bus driven by the on-board accelerometer controller.
- Answers register write (0x0A) and register read (0x0B) commands from a small emulated register file.
- Axis and temperature values come from fabric inputs.
- Used in simulation benches and in loopback builds, so the game and controller run without the physical sensor.

Parameters:
- SYNC_STAGES, 2, flops per synchronizer on SCLK, MOSI and SS (minimum 2).
- DEVID_AD, 8'hAD, value read at address 0x00.
- PARTID, 8'hF2, value read at address 0x02.

Ports:
- clk  in  1  system clock, 100MHz.
- reset  in  1  asynchronous, active-low reset.
- SCLK  in  1  SPI clock from master, mode 0, at most clk/8.
- MOSI  in  1  master-out data.
- SS  in  1  active-low slave select.
- MISO  out  1  slave-out data.
- accel_x_in  in  12  signed X sample.
- accel_y_in  in  12  signed Y sample.
- accel_z_in  in  12  signed Z sample.
- temp_in  in  12  signed temperature sample.
- power_ctl  out  8  current POWER_CTL register (0x2D).
- xfer_done  out  1  one-clk pulse at SS deassert after at least one complete byte.
- cmd_err  out  1  one-clk pulse when the command byte is not 0x0A or 0x0B.

Behaviour:
- Input sync: SCLK, MOSI and SS pass through SYNC_STAGES flops. Edges are detected on the synchronized signals. All logic runs on clk.
- Reset values:
  - MISO=0, power_ctl=0x00, xfer_done=0, cmd_err=0, state=IDLE.
  - Writable registers 0x20-0x2E = 0x00, except FILTER_CTL (0x2C) = 0x13.
- States: IDLE, CMD, ADDR, WRITE, READ, IGNORE.
- SS falling edge, from any state:
  - Go to CMD, bit_cnt=0.
  - Snapshot accel_x_in, accel_y_in, accel_z_in and temp_in, so multi-byte reads are coherent.
- SCLK rising edge while SS is low:
  - Shift MOSI into rx, MSB first; bit_cnt+1 modulo 8.
  - bit_cnt wrapping to 0 completes a byte.
- Byte complete in CMD:
  - 0x0A goes to ADDR, write mode.
  - 0x0B goes to ADDR, read mode.
  - Any other value goes to IGNORE and pulses cmd_err.
- Byte complete in ADDR: addr=rx, then WRITE or READ according to the mode.
- Byte complete in WRITE:
  - If addr is in 0x20-0x2E, reg[addr]=rx on the next clk. Other addresses are ignored.
  - Then addr+1, wrapping 0xFF to 0x00.
- Byte complete in READ: addr+1, wrapping 0xFF to 0x00.
- SCLK falling edge in READ:
  - If bit_cnt==0, load tx with reg[addr]; otherwise shift tx left.
  - MISO = tx[7] while in READ; MISO = 0 in all other states.
  - The first data bit is therefore valid before the first rising edge of the data phase.
- IGNORE: stays until SS rises; all bytes are discarded.
- SS rising edge:
  - Go to IDLE and force MISO to 0.
  - A partial byte is discarded and no write occurs.
  - xfer_done pulses if any byte completed during this select.
- Register read map:
  - 0x00: DEVID_AD.
  - 0x01: 0x1D.
  - 0x02: PARTID.
  - 0x03: 0x01.
  - 0x08, 0x09, 0x0A: x[11:4], y[11:4], z[11:4] (snapshot values).
  - 0x0B STATUS: bit0 = (power_ctl[1:0]==2'b10); other bits 0.
  - 0x0E/0x0F: x[7:0] / {4{x[11]}, x[11:8]}; 0x10/0x11 are the same for y; 0x12/0x13 for z; 0x14/0x15 for temp.
  - 0x20-0x2E: stored values.
  - All other addresses read 0x00.
- power_ctl always mirrors reg[0x2D] and updates the clk after the write completes.
- Asynchronous reset mid-transfer restores all reset values immediately. The next SS falling edge starts a fresh transaction.

Optional Feature:
- Macro: ADXL_SOFT_RESET_EN.
- Defined:
  - Writing 0x52 to 0x1F returns every writable register to its reset value on the clk after that byte completes. power_ctl returns to 0x00.
  - Writing any other value to 0x1F is ignored.
  - 0x1F reads 0x00.
- Not defined: 0x1F is an unmapped address; writes are ignored and reads return 0x00.

Test Plan:
- Read DEVID: SS low, send 0x0B, 0x00, then 4 dummy bytes -> MISO returns 0xAD, 0x1D, 0xF2, 0x01; xfer_done pulses once at SS rise.
- Burst axis read: set accel_x_in=12'hF35, accel_y_in=12'h07C; read from 0x0E for 4 bytes -> 0x35, 0xFF, 0x7C, 0x00. Change the inputs mid-burst -> the returned bytes do not change.
- Write then read: write 0x02 to 0x2D -> power_ctl=0x02 one clk after the byte completes; read 0x0B -> bit0=1; read 0x2C -> 0x13.
- Abort and errors:
  - Write 0x2D, then raise SS after 5 data bits -> power_ctl is unchanged.
  - Command 0x0D -> cmd_err pulses, MISO stays 0, no register changes.
- Reset mid-read: assert reset during the data phase of a 0x0B read -> MISO=0 and power_ctl=0x00 immediately; a following read of 0x00 returns 0xAD.
- With ADXL_SOFT_RESET_EN: write 0x02 to 0x2D, then 0x52 to 0x1F -> power_ctl=0x00; writing 0x51 to 0x1F -> no change.
